// File: rtl/apb_uart_txfifo_slave.sv
// ---------------------------------------------------------------------------
// apb_uart_txfifo_slave
//
// APB3 slave that collects bytes written by software into a TX FIFO and
// drains them to a UART transmitter over a valid/ready byte stream. A write
// to TXDATA while the FIFO is full is held off with PREADY wait states; if
// no space appears within WAIT_LIMIT wait cycles the write completes with
// PSLVERR, the byte is dropped and the sticky overflow flag is set.
//
// Register map (PADDR[3:2], PADDR[31:4] must be zero):
//   0 TXDATA  W   push PWDATA[7:0]
//   1 STATUS  R   [0] empty, [1] full, [2] overflow, [15:8] level
//   2 CTRL    RW  [0] tx_enable, [1] flush (write-1, self-clearing)
//   3 CLR     W   [2] write 1 to clear overflow
//
// Ports:
//   PCLK, PRESET      clock, synchronous active-high reset
//   PSEL, PENABLE,
//   PWRITE, PADDR,
//   PWDATA            APB3 request
//   PRDATA, PREADY,
//   PSLVERR           APB3 response (combinational)
//   TX_DATA, TX_VALID FIFO head byte towards the UART transmitter
//   TX_READY          transmitter accepts the head byte
// ---------------------------------------------------------------------------
module apb_uart_txfifo_slave #(
    parameter int DEPTH      = 16,
    parameter int WAIT_LIMIT = 8
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [7:0]  TX_DATA,
    output logic        TX_VALID,
    input  logic        TX_READY
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);

    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
    localparam logic [CW-1:0] WAIT_MAX   = CW'(WAIT_LIMIT);

    typedef enum logic [1:0] {
        REG_TXDATA = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_CLR    = 2'd3
    } reg_addr_e;

    // Registered state
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q,    wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,    rd_ptr_d;
    logic [LW-1:0] level_q,     level_d;
    logic          tx_enable_q, tx_enable_d;
    logic          overflow_q,  overflow_d;
    logic [CW-1:0] wait_cnt_q,  wait_cnt_d;

    // Decode
    reg_addr_e reg_sel;
    logic      access;
    logic      addr_err;
    logic      empty;
    logic      full;
    logic      txdata_wr;
    logic      stall;
    logic      drop;
    logic      push;
    logic      pop;
    logic      flush;
    logic      ctrl_wr;
    logic      clr_ovf;

    // Address LSBs and upper write-data bits carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{PADDR[1:0], PWDATA[31:8]};

    assign reg_sel  = reg_addr_e'(PADDR[3:2]);
    // Reset abandons any in-flight transfer: it is seen as a clean
    // zero-wait completion and causes no state change.
    assign access   = PSEL && PENABLE && !PRESET;
    assign addr_err = |PADDR[31:4];
    assign empty    = (level_q == '0);
    assign full     = (level_q == LEVEL_FULL);

    assign txdata_wr = access && PWRITE && !addr_err && (reg_sel == REG_TXDATA);
    assign stall     = txdata_wr && full && (wait_cnt_q <  WAIT_MAX);
    assign drop      = txdata_wr && full && (wait_cnt_q >= WAIT_MAX);
    assign push      = txdata_wr && !full;

    assign ctrl_wr   = access && PWRITE && !addr_err && (reg_sel == REG_CTRL);
    assign flush     = ctrl_wr && PWDATA[1];
    assign clr_ovf   = access && PWRITE && !addr_err && (reg_sel == REG_CLR) && PWDATA[2];

    // Stream side
    assign TX_VALID = tx_enable_q && !empty && !PRESET;
    assign TX_DATA  = mem_q[rd_ptr_q];
    assign pop      = TX_VALID && TX_READY;

    // APB response
    assign PREADY  = !stall;
    assign PSLVERR = access && (addr_err || drop);

    // NOTE: every signal written in an always_comb block gets a default at
    // the top so that no path leaves it unassigned and infers a latch.
    always_comb begin
        PRDATA = 32'd0;
        if (access && !PWRITE && !addr_err) begin
            unique case (reg_sel)
                REG_STATUS: PRDATA = {16'd0, 8'(level_q), 5'd0, overflow_q, full, empty};
                REG_CTRL:   PRDATA = {31'd0, tx_enable_q};
                default:    PRDATA = 32'd0;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        tx_enable_d = tx_enable_q;
        overflow_d  = overflow_q;
        wait_cnt_d  = '0;

        // Count only stalled access cycles; completion, an idle bus or a
        // setup phase all return the counter to zero.
        if (stall) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        // Push is blocked while full, so level never exceeds DEPTH.
        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        if (ctrl_wr) begin
            tx_enable_d = PWDATA[0];
        end

        // Flush overrides a same-cycle pop; a push cannot coincide because
        // both come from the single APB master.
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            level_d  = '0;
        end

        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample their _d values from the same pre-edge snapshot.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            tx_enable_q <= 1'b0;
            overflow_q  <= 1'b0;
            wait_cnt_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            tx_enable_q <= tx_enable_d;
            overflow_q  <= overflow_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; an entry is only
    // observable after it has been written, and leaving it out of reset lets
    // it map onto plain RAM/register-file cells.
    always_ff @(posedge PCLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= PWDATA[7:0];
        end
    end

endmodule

// File: tb/tb_apb_uart_txfifo_slave.sv
// ---------------------------------------------------------------------------
// tb_apb_uart_txfifo_slave
//
// Directed scenarios plus a randomized phase. A queue-based reference model
// updates once per cycle from the driven inputs and pushes the expected APB
// completion responses and expected stream bytes into scoreboards; a
// separate monitor pops and compares whenever the DUT completes a transfer
// or hands off a byte.
// ---------------------------------------------------------------------------
module tb_apb_uart_txfifo_slave;

    localparam int DEPTH      = 16;
    localparam int WAIT_LIMIT = 8;

    logic        PCLK     = 1'b0;
    logic        PRESET   = 1'b1;
    logic        PSEL     = 1'b0;
    logic        PENABLE  = 1'b0;
    logic        PWRITE   = 1'b0;
    logic [31:0] PADDR    = 32'd0;
    logic [31:0] PWDATA   = 32'd0;
    logic        TX_READY = 1'b0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;

    always #5 PCLK = ~PCLK;

    apb_uart_txfifo_slave #(
        .DEPTH      (DEPTH),
        .WAIT_LIMIT (WAIT_LIMIT)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .TX_DATA  (TX_DATA),
        .TX_VALID (TX_VALID),
        .TX_READY (TX_READY)
    );

    // ------------------------------------------------------------------
    // Check bookkeeping
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input string why);
        n_checks++;
        $display("FAIL %s: %s (t=%0t)", name, why, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model: FIFO as a byte queue, evaluated once per cycle at
    // the falling edge from the inputs the bench is driving.
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } apb_exp_t;

    apb_exp_t   apb_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] m_fifo[$];
    bit         m_en    = 0;
    bit         m_ovf   = 0;
    int         m_wait  = 0;
    bit         m_stall = 0;
    bit         m_valid = 0;

    always @(negedge PCLK) begin : ref_model
        bit       m_full;
        bit       m_push;
        bit       m_flush;
        bit       m_fire;
        apb_exp_t e;
        m_stall = 0;
        m_valid = 0;
        if (PRESET) begin
            m_fifo.delete();
            m_en   = 0;
            m_ovf  = 0;
            m_wait = 0;
        end else begin
            m_full  = (m_fifo.size() == DEPTH);
            m_valid = m_en && (m_fifo.size() != 0);
            m_fire  = m_valid && TX_READY;
            m_push  = 0;
            m_flush = 0;
            if (PSEL && PENABLE) begin
                e.rdata = 32'd0;
                e.err   = 1'b0;
                if (PADDR[31:4] != 28'd0) begin
                    e.err = 1'b1;
                end else if (PWRITE) begin
                    case (PADDR[3:2])
                        2'd0: begin
                            if (!m_full)                m_push  = 1;
                            else if (m_wait < WAIT_LIMIT) m_stall = 1;
                            else begin
                                e.err = 1'b1;
                                m_ovf = 1;
                            end
                        end
                        2'd2: begin
                            m_en    = PWDATA[0];
                            m_flush = PWDATA[1];
                        end
                        2'd3: if (PWDATA[2]) m_ovf = 0;
                        default: ;
                    endcase
                end else begin
                    case (PADDR[3:2])
                        2'd1: e.rdata = 32'(m_fifo.size()) * 256
                                      + (m_ovf ? 4 : 0) + (m_full ? 2 : 0)
                                      + ((m_fifo.size() == 0) ? 1 : 0);
                        2'd2: e.rdata = m_en ? 32'd1 : 32'd0;
                        default: e.rdata = 32'd0;
                    endcase
                end
                if (!m_stall) apb_q.push_back(e);
            end
            m_wait = m_stall ? m_wait + 1 : 0;
            if (m_fire)  tx_q.push_back(m_fifo.pop_front());
            if (m_flush) m_fifo.delete();
            if (m_push)  m_fifo.push_back(PWDATA[7:0]);
        end
    end

    // ------------------------------------------------------------------
    // Monitor: compares DUT outputs shortly after the falling edge.
    // ------------------------------------------------------------------
    always @(negedge PCLK) begin : monitor
        apb_exp_t e;
        #1;
        check("tx_valid", 32'(TX_VALID), 32'(m_valid));
        if (PSEL && PENABLE) begin
            if (PRESET) begin
                check("reset_pready",  32'(PREADY),  32'd1);
                check("reset_pslverr", 32'(PSLVERR), 32'd0);
            end else begin
                check("pready", 32'(PREADY), m_stall ? 32'd0 : 32'd1);
                if (PREADY) begin
                    if (apb_q.size() == 0) begin
                        fail_now("apb_completion", "DUT completed a transfer the model did not");
                    end else begin
                        e = apb_q.pop_front();
                        check("prdata",  PRDATA,        e.rdata);
                        check("pslverr", 32'(PSLVERR), 32'(e.err));
                    end
                end
            end
        end
        if (TX_VALID && TX_READY) begin
            if (tx_q.size() == 0) begin
                fail_now("tx_handshake", "DUT handed off a byte the model did not");
            end else begin
                check("tx_data", 32'(TX_DATA), 32'(tx_q.pop_front()));
            end
        end
    end

    // ------------------------------------------------------------------
    // APB driver (called at posedge+1, returns at posedge+1)
    // ------------------------------------------------------------------
    task automatic apb_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                            output logic [31:0] rdata, output logic err, output int waits);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = data;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        waits   = 0;
        rdata   = 32'd0;
        err     = 1'b0;
        forever begin
            @(negedge PCLK); #1;
            if (PREADY) begin
                rdata = PRDATA;
                err   = PSLVERR;
                break;
            end
            waits++;
            if (waits > 100) begin
                fail_now("apb_timeout", "PREADY stayed low for more than 100 cycles");
                break;
            end
            @(posedge PCLK); #1;
        end
        @(posedge PCLK); #1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
    endtask

    task automatic apb_wr(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] r;
        logic        e;
        int          w;
        apb_xfer(1'b1, addr, data, r, e, w);
    endtask

    task automatic apb_rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] r;
        logic        e;
        int          w;
        apb_xfer(1'b0, addr, 32'd0, r, e, w);
        check(name, r, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : stimulus
        logic [31:0] r;
        logic        e;
        int          w;
        logic [7:0]  fill[$];
        logic [7:0]  expb[$];

        repeat (3) @(posedge PCLK);
        #1;
        PRESET = 1'b0;

        // Reset state
        apb_rd_chk("reset_status", 32'h4, 32'h0000_0001);
        check("reset_tx_valid", 32'(TX_VALID), 32'd0);
        check("idle_pready",    32'(PREADY),   32'd1);

        // Three bytes queued while disabled, then drained back to back
        apb_wr(32'h0, 32'h41);
        apb_wr(32'h0, 32'h42);
        apb_wr(32'h0, 32'h43);
        apb_rd_chk("status_3", 32'h4, 32'h0000_0300);
        TX_READY = 1'b1;
        apb_wr(32'h8, 32'h1);
        for (int i = 0; i < 3; i++) begin
            check("stream_valid", 32'(TX_VALID), 32'd1);
            check("stream_byte",  32'(TX_DATA),  32'h41 + 32'(i));
            @(posedge PCLK); #1;
        end
        check("stream_done", 32'(TX_VALID), 32'd0);
        TX_READY = 1'b0;

        // Fill, then overflow after the full wait budget
        apb_wr(32'h8, 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            fill.push_back(8'($urandom));
            apb_wr(32'h0, 32'(fill[i]));
        end
        apb_rd_chk("status_full", 32'h4, 32'h0000_1002);
        apb_xfer(1'b1, 32'h0, 32'h55, r, e, w);
        check("ovf_waits",   32'(w), 32'(WAIT_LIMIT));
        check("ovf_pslverr", 32'(e), 32'd1);
        apb_rd_chk("status_ovf", 32'h4, 32'h0000_1006);
        apb_wr(32'hC, 32'h4);
        apb_rd_chk("status_clr", 32'h4, 32'h0000_1002);

        // Stalled write rescued by a pop in wait cycle 3
        apb_wr(32'h8, 32'h1);
        fork
            apb_xfer(1'b1, 32'h0, 32'h77, r, e, w);
            begin
                repeat (3) @(posedge PCLK);
                #1 TX_READY = 1'b1;
                @(posedge PCLK);
                #1 TX_READY = 1'b0;
            end
        join
        check("rescue_waits",   32'(w), 32'd3);
        check("rescue_pslverr", 32'(e), 32'd0);
        apb_rd_chk("status_rescue", 32'h4, 32'h0000_1002);
        for (int i = 1; i < DEPTH; i++) expb.push_back(fill[i]);
        expb.push_back(8'h77);
        TX_READY = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check("rescue_byte", 32'(TX_DATA), 32'(expb[i]));
            @(posedge PCLK); #1;
        end
        check("rescue_drained", 32'(TX_VALID), 32'd0);
        TX_READY = 1'b0;

        // Flush with a pop competing in the same cycle
        for (int i = 0; i < 5; i++) apb_wr(32'h0, 32'h60 + 32'(i));
        TX_READY = 1'b1;
        apb_wr(32'h8, 32'h3);
        check("flush_tx_valid", 32'(TX_VALID), 32'd0);
        apb_rd_chk("flush_status", 32'h4, 32'h0000_0001);
        apb_rd_chk("flush_ctrl",   32'h8, 32'h0000_0001);
        TX_READY = 1'b0;

        // Address errors
        apb_xfer(1'b0, 32'h10, 32'd0, r, e, w);
        check("badaddr_rd_err",   32'(e), 32'd1);
        check("badaddr_rd_rdata", r,      32'd0);
        apb_xfer(1'b1, 32'h18, 32'h0, r, e, w);
        check("badaddr_wr_err", 32'(e), 32'd1);
        apb_rd_chk("badaddr_ctrl_kept", 32'h8, 32'h0000_0001);

        // Reset in the middle of a stalled write
        apb_wr(32'h8, 32'h0);
        for (int i = 0; i < DEPTH; i++) apb_wr(32'h0, 32'($urandom_range(0, 255)));
        apb_wr(32'h0, 32'h55);
        apb_rd_chk("pre_reset_status", 32'h4, 32'h0000_1006);
        fork
            apb_xfer(1'b1, 32'h0, 32'h99, r, e, w);
            begin
                repeat (3) @(posedge PCLK);
                #1 PRESET = 1'b1;
                @(posedge PCLK);
                #1 PRESET = 1'b0;
            end
        join
        check("reset_xfer_waits",   32'(w), 32'd2);
        check("reset_xfer_pslverr", 32'(e), 32'd0);
        apb_rd_chk("post_reset_status", 32'h4, 32'h0000_0001);
        apb_rd_chk("post_reset_ctrl",   32'h8, 32'h0000_0000);

        // Randomized traffic, checked entirely by the scoreboard
        for (int i = 0; i < 300; i++) begin
            int          sel;
            bit          wrb;
            logic [31:0] a;
            logic [31:0] d;
            sel = $urandom_range(0, 9);
            d   = $urandom;
            wrb = 1'b1;
            if (sel <= 4) begin
                a = 32'h0;
            end else if (sel == 5) begin
                a   = 32'h4;
                wrb = 1'b0;
            end else if (sel == 6) begin
                a = 32'h8;
                d = {30'd0, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0)};
            end else if (sel == 7) begin
                a   = 32'($urandom_range(0, 3)) * 4;
                wrb = ($urandom_range(0, 1) == 1);
                if (a == 32'h8) d = d & 32'hFFFF_FFFD;
            end else if (sel == 8) begin
                a = 32'hC;
            end else begin
                a   = $urandom | 32'h10;
                wrb = ($urandom_range(0, 1) == 1);
            end
            a        = a | 32'($urandom_range(0, 3));
            TX_READY = ($urandom_range(0, 2) == 0);
            apb_xfer(wrb, a, d, r, e, w);
            idle($urandom_range(0, 2));
        end

        // Drain and confirm both scoreboards emptied
        apb_wr(32'h8, 32'h1);
        TX_READY = 1'b1;
        idle(2 * DEPTH + 4);
        TX_READY = 1'b0;
        idle(2);
        check("fifo_drained",  32'(TX_VALID),      32'd0);
        check("apb_q_empty",   32'(apb_q.size()),  32'd0);
        check("tx_q_empty",    32'(tx_q.size()),   32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
